vdec_hs_ctrl: RTL and testbench

Sequencer for the HS Viterbi decoder (rate 1/3, codeblocks of 1..29 bits, 8 tail bits). It accepts one decode request at a time and starts the forward ACS pass, which writes the path-traceback RAM. It then starts the backward traceback, captures the decoded bits and presents them with a valid/ack handshake. It sits between the HS channel front-end and the `vdec_hs_fwd`/`vdec_hs_bwd` engine pair, and it owns the watchdog for both engines.

---
 rtl/vdec_hs_pkg.sv | 22 ++
 rtl/vdec_hs_ctrl.sv | 139 +++++++++++++
 tb/tb_vdec_hs_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vdec_hs_pkg.sv
// Shared definitions for the HS Viterbi decoder control path: FSM encoding,
// codeblock limits and the decoded-bit mask helper.
package vdec_hs_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FWD_GO   = 3'd1,
        ST_FWD_WAIT = 3'd2,
        ST_BWD_GO   = 3'd3,
        ST_BWD_WAIT = 3'd4,
        ST_RESULT   = 3'd5
    } vdec_hs_state_t;

    localparam logic [4:0] VDEC_HS_MAX_SIZE = 5'd29;
    localparam logic [3:0] VDEC_HS_TAIL     = 4'd8;

    // (1<<size)-1 computed one bit wider so size 29 yields all ones.
    function automatic logic [28:0] size_mask(input logic [4:0] size);
        return 29'((30'd1 << size) - 30'd1);
    endfunction

endpackage

// File: rtl/vdec_hs_ctrl.sv
// HS Viterbi decoder sequencer: accepts one request, runs the forward ACS pass
// then the traceback, and returns the masked decoded bits with a watchdog per phase.
module vdec_hs_ctrl
    import vdec_hs_pkg::*;
#(
    parameter int TMO_CYC = 511
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_size,
    output logic        fwd_start,
    output logic [5:0]  fwd_size_p7,
    input  logic        fwd_done,
    output logic        bwd_start,
    output logic [5:0]  bwd_size_p7,
    input  logic        bwd_done,
    input  logic [28:0] bwd_dec_bits,
    output logic        res_valid,
    input  logic        res_ack,
    output logic [28:0] res_bits,
    output logic        res_err,
    output logic        busy
);

    localparam logic [9:0] TMO_LIM  = 10'(TMO_CYC);
    localparam logic [9:0] WDOG_SAT = 10'h3FF;

    vdec_hs_state_t state_q, state_d;
    logic [4:0]  size_q;
    logic [9:0]  wdog_q;
    logic        ld_size, ld_res, wdog_clr, res_err_d;
    logic [28:0] res_bits_d;
    logic        accept, size_ok, tmo, in_wait;

    assign accept  = req_valid && req_ready && (state_q == ST_IDLE);
    assign size_ok = (req_size != 5'd0) && (req_size <= VDEC_HS_MAX_SIZE);
    assign tmo     = (wdog_q == TMO_LIM);
    assign in_wait = (state_q == ST_FWD_WAIT) || (state_q == ST_BWD_WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Done pulses are checked before the watchdog so a late done still wins.
    always_comb begin
        state_d    = state_q;
        ld_size    = 1'b0;
        ld_res     = 1'b0;
        wdog_clr   = 1'b0;
        res_err_d  = 1'b0;
        res_bits_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (size_ok) begin
                        ld_size = 1'b1;
                        state_d = ST_FWD_GO;
                    end else begin
                        ld_res    = 1'b1;
                        res_err_d = 1'b1;
                        state_d   = ST_RESULT;
                    end
                end
            end
            ST_FWD_GO: begin
                wdog_clr = 1'b1;
                state_d  = ST_FWD_WAIT;
            end
            ST_FWD_WAIT: begin
                if (fwd_done) begin
                    state_d = ST_BWD_GO;
                end else if (tmo) begin
                    ld_res    = 1'b1;
                    res_err_d = 1'b1;
                    state_d   = ST_RESULT;
                end
            end
            ST_BWD_GO: begin
                wdog_clr = 1'b1;
                state_d  = ST_BWD_WAIT;
            end
            ST_BWD_WAIT: begin
                if (bwd_done) begin
                    ld_res     = 1'b1;
                    res_bits_d = bwd_dec_bits & size_mask(size_q);
                    state_d    = ST_RESULT;
                end else if (tmo) begin
                    ld_res    = 1'b1;
                    res_err_d = 1'b1;
                    state_d   = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (res_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Status outputs are decoded from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready   <= 1'b0;
            busy        <= 1'b0;
            fwd_start   <= 1'b0;
            bwd_start   <= 1'b0;
            res_valid   <= 1'b0;
            res_err     <= 1'b0;
            res_bits    <= '0;
            size_q      <= '0;
            fwd_size_p7 <= '0;
            bwd_size_p7 <= '0;
            wdog_q      <= '0;
        end else begin
            req_ready <= (state_d == ST_IDLE);
            busy      <= (state_d != ST_IDLE);
            fwd_start <= (state_d == ST_FWD_GO);
            bwd_start <= (state_d == ST_BWD_GO);
            res_valid <= (state_d == ST_RESULT);
            if (ld_size) begin
                size_q      <= req_size;
                fwd_size_p7 <= {1'b0, req_size} + 6'(VDEC_HS_TAIL - 4'd1);
                bwd_size_p7 <= {1'b0, req_size} + 6'(VDEC_HS_TAIL - 4'd1);
            end
            if (ld_res) begin
                res_bits <= res_bits_d;
                res_err  <= res_err_d;
            end
            if (wdog_clr)
                wdog_q <= '0;
            else if (in_wait && (wdog_q != WDOG_SAT))
                wdog_q <= wdog_q + 10'd1;
        end
    end

endmodule

// File: tb/tb_vdec_hs_ctrl.sv
// Scoreboard bench for vdec_hs_ctrl with delay-programmable forward/traceback stubs.
`timescale 1ns/1ps
module tb_vdec_hs_ctrl;

    typedef struct packed {
        logic [28:0] bits;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid, req_ready, fwd_start, fwd_done, bwd_start, bwd_done;
    logic        res_valid, res_ack, res_err, busy;
    logic [4:0]  req_size;
    logic [5:0]  fwd_size_p7, bwd_size_p7;
    logic [28:0] bwd_dec_bits, res_bits;
    logic        fwd_done_stub, fwd_stray, bwd_done_stub, bwd_stray;

    int   n_chk = 0, n_fail = 0, cyc = 0;
    int   fwd_lat = 10, bwd_lat = 10, fwd_cnt = 0, bwd_cnt = 0;
    bit   fwd_en = 1'b1;
    int   fwd_done_cyc = 0, bwd_done_cyc = 0, fwd_start_cyc = 0, bwd_start_cyc = 0;
    int   n_fwd = 0, n_bwd = 0, res_cyc = 0;
    exp_t sbq[$];

    assign fwd_done = fwd_done_stub | fwd_stray;
    assign bwd_done = bwd_done_stub | bwd_stray;

    always #5 clk = ~clk;

    vdec_hs_ctrl #(.TMO_CYC(511)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_size(req_size),
        .fwd_start(fwd_start), .fwd_size_p7(fwd_size_p7), .fwd_done(fwd_done),
        .bwd_start(bwd_start), .bwd_size_p7(bwd_size_p7), .bwd_done(bwd_done),
        .bwd_dec_bits(bwd_dec_bits),
        .res_valid(res_valid), .res_ack(res_ack), .res_bits(res_bits),
        .res_err(res_err), .busy(busy)
    );

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Forward stub: done pulse fwd_lat cycles after the start pulse.
    initial begin
        fwd_done_stub = 1'b0;
        forever begin
            @(negedge clk);
            fwd_done_stub = 1'b0;
            if (rst) fwd_cnt = 0;
            else begin
                if (fwd_cnt > 0) begin
                    fwd_cnt--;
                    if (fwd_cnt == 0) begin
                        fwd_done_stub = 1'b1;
                        fwd_done_cyc  = cyc;
                    end
                end
                if (fwd_start && fwd_en) fwd_cnt = fwd_lat;
            end
        end
    end

    initial begin
        bwd_done_stub = 1'b0;
        forever begin
            @(negedge clk);
            bwd_done_stub = 1'b0;
            if (rst) bwd_cnt = 0;
            else begin
                if (bwd_cnt > 0) begin
                    bwd_cnt--;
                    if (bwd_cnt == 0) begin
                        bwd_done_stub = 1'b1;
                        bwd_done_cyc  = cyc;
                    end
                end
                if (bwd_start) bwd_cnt = bwd_lat;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (fwd_start) begin n_fwd++; fwd_start_cyc = cyc; end
        if (bwd_start) begin n_bwd++; bwd_start_cyc = cyc; end
    end

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL global_timeout: cycle %0d reached, required end before 50000", cyc);
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input logic [28:0] bits, input logic err);
        exp_t e;
        e.bits = bits;
        e.err  = err;
        sbq.push_back(e);
    endtask

    task automatic do_req(input logic [4:0] sz);
        int n = 0;
        while (!req_ready && n < 2000) begin @(negedge clk); n++; end
        if (!req_ready) chk("req_ready_wait", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_size  = sz;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input int hold);
        int          n = 0;
        logic [28:0] held;
        bit          ok;
        exp_t        e;
        while (!res_valid && n < 1000) begin @(negedge clk); n++; end
        chk({tag, "_valid"}, 32'(res_valid), 32'd1);
        res_cyc = cyc;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk({tag, "_bits"}, 32'(res_bits), 32'(e.bits));
            chk({tag, "_err"},  32'(res_err),  32'(e.err));
        end else begin
            chk({tag, "_sb_empty"}, 32'(sbq.size()), 32'd1);
        end
        held = res_bits;
        ok   = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            if (res_bits !== held || !res_valid || req_ready) ok = 1'b0;
        end
        if (hold > 0) chk({tag, "_hold_stable"}, 32'(ok), 32'd1);
        res_ack = 1'b1;
        @(negedge clk);
        res_ack = 1'b0;
        chk({tag, "_ack_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_ack_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int f0, b0, n, d;
        logic [4:0] bad [2];
        bad[0] = 5'd0;
        bad[1] = 5'd31;
        req_valid = 1'b0; req_size = '0; res_ack = 1'b0;
        fwd_stray = 1'b0; bwd_stray = 1'b0; bwd_dec_bits = '0;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_fwd_start", 32'(fwd_start), 32'd0);
        chk("rst_bwd_start", 32'(bwd_start), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_err",   32'(res_err),   32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_res_bits",  32'(res_bits),  32'd0);
        chk("rst_fwd_p7",    32'(fwd_size_p7), 32'd0);
        chk("rst_bwd_p7",    32'(bwd_size_p7), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_req_ready", 32'(req_ready), 32'd1);

        // full-size codeblock with realistic engine latencies
        fwd_lat = 300; bwd_lat = 45; bwd_dec_bits = 29'h1ABCDEF0;
        f0 = n_fwd; b0 = n_bwd;
        sb_push(29'h1ABCDEF0, 1'b0);
        do_req(5'd29);
        chk("t1_fwd_start_lat", 32'(fwd_start), 32'd1);
        chk("t1_fwd_p7", 32'(fwd_size_p7), 32'd36);
        chk("t1_busy", 32'(busy), 32'd1);
        wait_result("t1", 0);
        chk("t1_bwd_start_lat", 32'(bwd_start_cyc - fwd_done_cyc), 32'd1);
        chk("t1_res_lat", 32'(res_cyc - bwd_done_cyc), 32'd1);
        chk("t1_fwd_cnt", 32'(n_fwd - f0), 32'd1);
        chk("t1_bwd_cnt", 32'(n_bwd - b0), 32'd1);

        // masking of bits above size-1
        fwd_lat = 10; bwd_lat = 5; bwd_dec_bits = 29'h1FFFFFFF;
        sb_push(29'h1F, 1'b0);
        do_req(5'd5);
        wait_result("t2", 0);
        chk("t2_bwd_p7", 32'(bwd_size_p7), 32'd12);
        chk("t2_fwd_p7", 32'(fwd_size_p7), 32'd12);

        // illegal sizes rejected without starting an engine
        for (int i = 0; i < 2; i++) begin
            f0 = n_fwd;
            sb_push(29'h0, 1'b1);
            do_req(bad[i]);
            chk($sformatf("t3_%0d_res_lat", bad[i]), 32'(res_valid), 32'd1);
            wait_result($sformatf("t3_%0d", bad[i]), 0);
            chk($sformatf("t3_%0d_no_fwd", bad[i]), 32'(n_fwd - f0), 32'd0);
            chk($sformatf("t3_%0d_p7_kept", bad[i]), 32'(fwd_size_p7), 32'd12);
        end

        // forward pass never completes: watchdog fires
        fwd_en = 1'b0;
        f0 = n_fwd; b0 = n_bwd;
        sb_push(29'h0, 1'b1);
        do_req(5'd10);
        wait_result("t4", 0);
        d = res_cyc - fwd_start_cyc;
        chk("t4_tmo_window", 32'(d >= 511 && d <= 513), 32'd1);
        chk("t4_fwd_cnt", 32'(n_fwd - f0), 32'd1);
        chk("t4_no_bwd", 32'(n_bwd - b0), 32'd0);
        fwd_en = 1'b1;

        // ack withheld, then stray pulses and stray ack in IDLE
        bwd_dec_bits = 29'h0F0F0F0F;
        sb_push(29'h0F0F0F0F, 1'b0);
        do_req(5'd29);
        wait_result("t5", 100);
        f0 = n_fwd; b0 = n_bwd;
        fwd_stray = 1'b1;
        @(negedge clk);
        fwd_stray = 1'b0; bwd_stray = 1'b1;
        @(negedge clk);
        bwd_stray = 1'b0; res_ack = 1'b1;
        @(negedge clk);
        res_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5_stray_busy", 32'(busy), 32'd0);
        chk("t5_stray_ready", 32'(req_ready), 32'd1);
        chk("t5_stray_valid", 32'(res_valid), 32'd0);
        chk("t5_stray_fwd", 32'(n_fwd - f0), 32'd0);
        chk("t5_stray_bwd", 32'(n_bwd - b0), 32'd0);

        // reset during traceback, then a clean request
        fwd_lat = 5; bwd_lat = 200; bwd_dec_bits = 29'h1234567;
        b0 = n_bwd;
        do_req(5'd8);
        n = 0;
        while (n_bwd == b0 && n < 100) begin @(negedge clk); n++; end
        chk("t6_bwd_started", 32'(n_bwd - b0), 32'd1);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_rst_ready", 32'(req_ready), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_valid", 32'(res_valid), 32'd0);
        chk("t6_rst_bwd_start", 32'(bwd_start), 32'd0);
        chk("t6_rst_bits", 32'(res_bits), 32'd0);
        chk("t6_rst_fwd_p7", 32'(fwd_size_p7), 32'd0);
        chk("t6_rst_bwd_p7", 32'(bwd_size_p7), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        bwd_lat = 20;
        sb_push(29'h567, 1'b0);
        do_req(5'd12);
        wait_result("t6b", 0);
        chk("t6b_bwd_p7", 32'(bwd_size_p7), 32'd19);
        chk("sb_drained", 32'(sbq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
